// File: rtl/mario_motion_ctrl.sv
// Player sprite motion controller: tick-driven horizontal walking with clamping
// and a four-phase jump (IDLE, RISE, HOLD, FALL) with gravity and a fall speed cap.
module mario_motion_ctrl #(
    parameter int X_START   = 32,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 608,
    parameter int Y_GROUND  = 400,
    parameter int STEP      = 2,
    parameter int JUMP_V0   = 12,
    parameter int GRAVITY   = 1,
    parameter int VMAX      = 15,
    parameter int APEX_HOLD = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_jump_btn,
    output logic [9:0] o_pos_x,
    output logic [9:0] o_pos_y,
    output logic       o_jump,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_HOLD = 2'd2,
        S_FALL = 2'd3
    } state_t;

    localparam logic [10:0] L_X_MIN    = 11'(X_MIN);
    localparam logic [10:0] L_X_MAX    = 11'(X_MAX);
    localparam logic [10:0] L_STEP     = 11'(STEP);
    localparam logic [10:0] L_Y_GROUND = 11'(Y_GROUND);

    state_t      r_state;
    logic [9:0]  r_pos_x;
    logic [9:0]  r_pos_y;
    logic [5:0]  r_vy;
    logic [7:0]  r_hold;
    logic        r_jump;
    logic        r_jump_req;
    logic        r_jump_btn_q;

    logic [10:0] w_x_wide;
    logic [9:0]  w_x_next;
    logic [9:0]  w_rise_y;
    logic        w_rise_done;
    logic [5:0]  w_vy_dec;
    logic [6:0]  w_vy_sum;
    logic [5:0]  w_fall_vy;
    logic [10:0] w_fall_sum;
    logic        w_land;
    logic        w_btn_edge;

    // All intermediate comparisons are done one bit wider so neither the left
    // clamp nor the landing test can wrap around.
    always_comb begin
        w_x_wide = {1'b0, r_pos_x};
        w_x_next = r_pos_x;
        if (i_left && !i_right) begin
            w_x_next = (w_x_wide >= L_X_MIN + L_STEP) ? 10'(w_x_wide - L_STEP) : 10'(L_X_MIN);
        end else if (i_right && !i_left) begin
            w_x_next = (w_x_wide + L_STEP > L_X_MAX) ? 10'(L_X_MAX) : 10'(w_x_wide + L_STEP);
        end

        w_rise_y    = ({1'b0, r_pos_y} >= {5'd0, r_vy}) ? (r_pos_y - {4'd0, r_vy}) : 10'd0;
        w_rise_done = ({1'b0, r_vy} <= 7'(GRAVITY));
        w_vy_dec    = r_vy - 6'(GRAVITY);

        w_vy_sum    = {1'b0, r_vy} + 7'(GRAVITY);
        w_fall_vy   = (w_vy_sum > 7'(VMAX)) ? 6'(VMAX) : w_vy_sum[5:0];
        w_fall_sum  = {1'b0, r_pos_y} + {5'd0, w_fall_vy};
        w_land      = (w_fall_sum >= L_Y_GROUND);

        w_btn_edge  = i_jump_btn & ~r_jump_btn_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pos_x      <= 10'(X_START);
            r_pos_y      <= 10'(Y_GROUND);
            r_vy         <= 6'd0;
            r_hold       <= 8'd0;
            r_jump       <= 1'b0;
            r_jump_req   <= 1'b0;
            r_jump_btn_q <= 1'b0;
        end else begin
            r_jump_btn_q <= i_jump_btn;

            // Presses made while airborne are dropped by the next tick.
            if (i_tick && r_state != S_IDLE) begin
                r_jump_req <= 1'b0;
            end else if (w_btn_edge) begin
                r_jump_req <= 1'b1;
            end else if (i_tick) begin
                r_jump_req <= 1'b0;
            end

            if (i_tick) begin
                r_pos_x <= w_x_next;
                case (r_state)
                    S_IDLE: begin
                        if (r_jump_req) begin
                            r_state <= S_RISE;
                            r_jump  <= 1'b1;
                            r_vy    <= 6'(JUMP_V0);
                        end
                    end
                    S_RISE: begin
                        r_pos_y <= w_rise_y;
                        if (w_rise_done) begin
                            r_state <= S_HOLD;
                            r_vy    <= 6'd0;
                            r_hold  <= 8'(APEX_HOLD);
                        end else begin
                            r_vy <= w_vy_dec;
                        end
                    end
                    S_HOLD: begin
                        r_hold <= r_hold - 8'd1;
                        if (r_hold <= 8'd1) begin
                            r_state <= S_FALL;
                            r_vy    <= 6'd0;
                        end
                    end
                    S_FALL: begin
                        if (w_land) begin
                            r_pos_y <= 10'(Y_GROUND);
                            r_vy    <= 6'd0;
                            r_state <= S_IDLE;
                            r_jump  <= 1'b0;
                        end else begin
                            r_pos_y <= w_fall_sum[9:0];
                            r_vy    <= w_fall_vy;
                        end
                    end
                endcase
            end
        end
    end

    assign o_pos_x = r_pos_x;
    assign o_pos_y = r_pos_y;
    assign o_jump  = r_jump;
    assign o_state = r_state;

endmodule

// File: doc/mario_motion_ctrl.md
Name: mario_motion_ctrl

Overview:
- Frame-tick-driven motion controller for the player sprite.
- Tracks horizontal position from left/right inputs and runs the jump sequence: IDLE, RISE, HOLD, FALL.
- Drives the `jump` level consumed by the sprite animation block; that block freezes walk frames while `jump`=1.
- Drives `pos_x`/`pos_y` to the VGA renderer.

Parameters:
- X_START, 32: pos_x reset value (px).
- X_MIN, 0: left bound of pos_x.
- X_MAX, 608: right bound of pos_x.
- Y_GROUND, 400: ground line; pos_y reset and landing value.
- STEP, 2: horizontal px per tick.
- JUMP_V0, 12: initial upward speed (px/tick).
- GRAVITY, 1: speed change per tick.
- VMAX, 15: fall speed cap.
- APEX_HOLD, 4: ticks spent in HOLD.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  one-cycle frame strobe; all motion updates occur only on cycles with tick=1.
- left  in  1  left button level.
- right  in  1  right button level.
- jump_btn  in  1  jump button level.
- pos_x  out  10  sprite x (px).
- pos_y  out  10  sprite y (px, top = 0).
- jump  out  1  1 whenever state != IDLE.
- state  out  2  IDLE=0, RISE=1, HOLD=2, FALL=3.

Behaviour:
- Reset, on a clk edge with rst=1:
  - pos_x=X_START, pos_y=Y_GROUND, state=IDLE, jump=0.
  - Internal vy=0, hold counter=0, jump_req=0, jump_btn_q=0.
  - rst dominates tick and all other inputs; mid-jump reset returns to the ground immediately.
- Jump request:
  - jump_btn_q registers jump_btn every cycle.
  - A rising edge (jump_btn & ~jump_btn_q) sets jump_req on any cycle.
  - On a tick in IDLE with jump_req=1: consume it, clear jump_req.
  - On a tick in any other state: clear jump_req. Presses made in the air are not buffered.
  - Holding the button does not re-jump; a new edge is required.
- Horizontal, per tick, in all states:
  - left & ~right: pos_x = max(pos_x-STEP, X_MIN). Compute without unsigned underflow.
  - right & ~left: pos_x = min(pos_x+STEP, X_MAX).
  - Both or neither pressed: hold.
- State machine, per tick:
  - IDLE: if jump_req, go to RISE with vy=JUMP_V0; pos_y unchanged this tick.
  - RISE: pos_y = max(pos_y - vy, 0); vy = vy - GRAVITY. If the new vy <= 0, go to HOLD with vy=0 and hold counter=APEX_HOLD.
  - HOLD: pos_y fixed; decrement the counter. When the counter reaches 0, go to FALL (vy=0).
  - FALL: vy_n = min(vy+GRAVITY, VMAX). If pos_y + vy_n >= Y_GROUND, set pos_y=Y_GROUND, vy=0 and go to IDLE. Otherwise pos_y += vy_n, vy = vy_n.
- Latency:
  - Outputs are registered; a change is visible the cycle after the tick edge.
  - jump rises on the same edge that enters RISE.
- Arithmetic: vy is 6-bit unsigned; intermediate sums use 11 bits to avoid overflow.
- No state change and no pos update occur on cycles with tick=0.
- left/right simultaneous with a jump tick: both the horizontal and vertical updates apply on that tick.

Test Plan:
- Reset: assert rst for 2 cycles, with ticks present -> pos_x=32, pos_y=400, state=0, jump=0.
- Walk right: right=1 for 10 ticks -> pos_x=52. Left and right both held for 5 ticks -> pos_x stays 52. Right held from 606 -> clamps at 608. Left held from 1 -> clamps at 0.
- Full jump with defaults:
  - Pulse jump_btn, then ticks -> jump=1 on the first tick.
  - After 12 RISE ticks pos_y=322 and state=HOLD.
  - HOLD lasts 4 ticks at 322.
  - FALL for 12 ticks, landing at pos_y=400, state=IDLE, jump=0.
  - Total 1+12+4+12 = 29 ticks from press to landing.
- Air press / held button: a second edge during RISE -> no re-jump after landing. Holding jump_btn high through the landing -> stays IDLE.
- No tick: toggle jump_btn and left with tick=0 for 50 cycles -> positions and state unchanged. jump_req is set and fires on the first tick.
- Reset mid-jump: assert rst during HOLD -> next cycle pos_y=400, state=IDLE, jump=0, and no residual request.
